// File: rtl/clb_cfg_if.sv
// Configuration port bundle for clb_cfg_loader: serial frame input and
// committed CLB mode / status outputs.
interface clb_cfg_if #(
  parameter int unsigned N_CLB = 8
);
  logic                 cfg_start_i;
  logic                 cfg_valid_i;
  logic                 cfg_data_i;
  logic [2*N_CLB-1:0]   cfg_mode_o;
  logic                 cfg_busy_o;
  logic                 cfg_done_o;
  logic                 cfg_err_o;

  modport master (
    output cfg_start_i, cfg_valid_i, cfg_data_i,
    input  cfg_mode_o, cfg_busy_o, cfg_done_o, cfg_err_o
  );

  modport slave (
    input  cfg_start_i, cfg_valid_i, cfg_data_i,
    output cfg_mode_o, cfg_busy_o, cfg_done_o, cfg_err_o
  );
endinterface

// File: rtl/clb_cfg_loader.sv
// Serial CLB mode loader: shifts a parity-protected frame into a shadow
// register and commits it to the CLB mode pins only when parity checks.
module clb_cfg_loader #(
  parameter int unsigned N_CLB = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  clb_cfg_if.slave     cfg
);

  localparam int unsigned W  = 2 * N_CLB;
  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    shadow_q, shadow_d;
  logic            par_q, par_d;
  logic [W-1:0]    mode_q, mode_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      par_q    <= 1'b0;
      mode_q   <= '1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      par_q    <= par_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // par_q is the running XOR of every accepted bit, so a clean frame leaves it 0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    par_d    = par_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    err_d    = err_q;

    unique case (state_q)
      IDLE: begin
        if (cfg.cfg_start_i) begin
          state_d  = SHIFT;
          cnt_d    = '0;
          shadow_d = '0;
          par_d    = 1'b0;
          err_d    = 1'b0;
        end
      end
      SHIFT: begin
        if (cfg.cfg_start_i) begin
          cnt_d    = '0;
          shadow_d = '0;
          par_d    = 1'b0;
        end else if (cfg.cfg_valid_i) begin
          par_d = par_q ^ cfg.cfg_data_i;
          if (cnt_q < CW'(W)) begin
            shadow_d = {shadow_q[W-2:0], cfg.cfg_data_i};
            cnt_d    = cnt_q + 1'b1;
          end else begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (!par_q) begin
          mode_d = shadow_q;
          done_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign cfg.cfg_mode_o = mode_q;
  assign cfg.cfg_busy_o = busy_q;
  assign cfg.cfg_done_o = done_q;
  assign cfg.cfg_err_o  = err_q;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Randomized scoreboard bench for clb_cfg_loader with N_CLB=2 (4 payload bits + parity).
module tb_clb_cfg_loader;

  localparam int unsigned N = 2;
  localparam int unsigned W = 2 * N;

  typedef struct {
    bit           is_err;
    logic [W-1:0] mode;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  exp_t q[$];
  bit   rst_at_edge;
  bit   mon_en;

  clb_cfg_if #(.N_CLB(N)) cfg();

  clb_cfg_loader #(.N_CLB(N)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .cfg    (cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rst_at_edge = rst_n;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected frame outcomes whenever the DUT reports done or a new error.
  initial begin : monitor
    logic [W-1:0] model_mode;
    logic         err_prev;
    exp_t         e;
    model_mode = '1;
    err_prev   = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!rst_at_edge) begin
          model_mode = '1;
          check("reset_mode", cfg.cfg_mode_o, '1);
          check("reset_busy", W'(cfg.cfg_busy_o), '0);
          check("reset_done", W'(cfg.cfg_done_o), '0);
          check("reset_err",  W'(cfg.cfg_err_o),  '0);
        end else begin
          if (cfg.cfg_done_o === 1'b1) begin
            if (q.size() == 0) begin
              check("unexpected_done", 1, 0);
            end else begin
              e = q.pop_front();
              check("done_kind", W'(e.is_err), '0);
              if (!e.is_err) model_mode = e.mode;
              check("done_busy", W'(cfg.cfg_busy_o), '0);
            end
          end
          if (cfg.cfg_err_o === 1'b1 && err_prev === 1'b0) begin
            if (q.size() == 0) begin
              check("unexpected_err", 1, 0);
            end else begin
              e = q.pop_front();
              check("err_kind", W'(e.is_err), W'(1));
            end
          end
          check("mode", cfg.cfg_mode_o, model_mode);
        end
        err_prev = cfg.cfg_err_o;
      end
    end
  end

  task automatic cyc(input bit s, input bit v, input bit d);
    cfg.cfg_start_i = s;
    cfg.cfg_valid_i = v;
    cfg.cfg_data_i  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(0, 0, 1'($urandom));
  endtask

  task automatic do_reset(input int unsigned n);
    rst_n = 1'b0;
    idle(n);
    rst_n = 1'b1;
  endtask

  // Full frame: start (optionally with a junk valid bit), payload MSB first, then parity.
  task automatic send_frame(input logic [W-1:0] val, input bit par,
                            input int unsigned gapmax, input bit noise);
    exp_t e;
    cyc(1, noise, noise);
    check("start_err_clear", W'(cfg.cfg_err_o), '0);
    check("start_busy", W'(cfg.cfg_busy_o), W'(1));
    for (int i = int'(W) - 1; i >= 0; i--) begin
      idle($urandom_range(0, gapmax));
      cyc(0, 1, val[i]);
    end
    idle($urandom_range(0, gapmax));
    e.is_err = ((^val) ^ par);
    e.mode   = val;
    q.push_back(e);
    cyc(0, 1, par);
    check("check_busy", W'(cfg.cfg_busy_o), W'(1));
  endtask

  initial begin : stim
    tests = 0;
    fails = 0;
    mon_en = 1'b0;
    rst_n = 1'b0;
    cfg.cfg_start_i = 1'b0;
    cfg.cfg_valid_i = 1'b0;
    cfg.cfg_data_i  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    rst_n = 1'b1;
    check("init_mode", cfg.cfg_mode_o, 4'b1111);
    check("init_busy", W'(cfg.cfg_busy_o), '0);

    // Basic commit and error frames.
    send_frame(4'b0110, 1'b0, 0, 1'b0);
    idle(3);
    check("after_commit_mode", cfg.cfg_mode_o, 4'b0110);
    check("after_commit_busy", W'(cfg.cfg_busy_o), '0);
    do_reset(1);
    send_frame(4'b0110, 1'b1, 0, 1'b0);
    idle(3);
    check("after_err_mode", cfg.cfg_mode_o, 4'b1111);
    check("err_sticky", W'(cfg.cfg_err_o), W'(1));

    // Gaps between bits; start clears err (checked inside send_frame).
    cfg.cfg_start_i = 1'b1;
    cfg.cfg_valid_i = 1'b0;
    @(posedge clk); #1;
    cfg.cfg_start_i = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      idle(3);
      cyc(0, 1, (i == 3));
    end
    idle(3);
    begin
      exp_t e;
      e.is_err = 1'b0;
      e.mode   = 4'b1000;
      q.push_back(e);
    end
    cyc(0, 1, 1'b1);
    idle(3);
    check("gap_mode", cfg.cfg_mode_o, 4'b1000);

    // Restart mid-frame; the restart cycle's valid data bit is discarded.
    cyc(1, 0, 0);
    cyc(0, 1, 1);
    cyc(0, 1, 1);
    send_frame(4'b0011, 1'b0, 0, 1'b1);
    idle(2);
    check("restart_mode", cfg.cfg_mode_o, 4'b0011);
    check("restart_err", W'(cfg.cfg_err_o), '0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 1'($urandom));
    check("idle_bits_busy", W'(cfg.cfg_busy_o), '0);

    // Reset mid-frame, then bits without start are ignored.
    send_frame(4'b0110, 1'b0, 0, 1'b0);
    idle(2);
    cyc(1, 0, 0);
    cyc(0, 1, 1); cyc(0, 1, 0); cyc(0, 1, 1);
    do_reset(1);
    check("midreset_mode", cfg.cfg_mode_o, 4'b1111);
    for (int i = 0; i < 6; i++) cyc(0, 1, 1'($urandom));
    check("midreset_busy", W'(cfg.cfg_busy_o), '0);

    // Reset landing on the CHECK cycle must suppress the commit.
    cyc(1, 0, 0);
    cyc(0, 1, 0); cyc(0, 1, 1); cyc(0, 1, 0); cyc(0, 1, 1);
    cyc(0, 1, 0);
    do_reset(1);
    idle(3);
    check("check_reset_mode", cfg.cfg_mode_o, 4'b1111);

    // Random frames with random gaps, restarts and stray idle bits.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        cyc(1, 0, 0);
        for (int unsigned k = $urandom_range(0, W); k > 0; k--) cyc(0, 1, 1'($urandom));
      end
      send_frame(W'($urandom_range(0, 15)), 1'($urandom), $urandom_range(0, 2),
                 1'($urandom));
      for (int unsigned k = $urandom_range(1, 4); k > 0; k--)
        cyc(0, 1'($urandom), 1'($urandom));
    end

    idle(5);
    check("queue_drained", W'(q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
